// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csr_pkg
//  Description : CSR addresses, csr_op encoding, trap cause codes and
//                mstatus/mip bit positions shared by the CSR file.
//  Revision    : 1.0 - initial release
// ============================================================================
package csr_pkg;

    // CSR addresses
    localparam logic [11:0] c_addr_mstatus    = 12'h300;
    localparam logic [11:0] c_addr_misa       = 12'h301;
    localparam logic [11:0] c_addr_mie        = 12'h304;
    localparam logic [11:0] c_addr_mtvec      = 12'h305;
    localparam logic [11:0] c_addr_mscratch   = 12'h340;
    localparam logic [11:0] c_addr_mepc       = 12'h341;
    localparam logic [11:0] c_addr_mcause     = 12'h342;
    localparam logic [11:0] c_addr_mtval      = 12'h343;
    localparam logic [11:0] c_addr_mip        = 12'h344;
    localparam logic [11:0] c_addr_mcycle     = 12'hB00;
    localparam logic [11:0] c_addr_minstret   = 12'hB02;
    localparam logic [11:0] c_addr_mcycleh    = 12'hB80;
    localparam logic [11:0] c_addr_minstreth  = 12'hB82;
    localparam logic [11:0] c_addr_cycle      = 12'hC00;
    localparam logic [11:0] c_addr_instret    = 12'hC02;
    localparam logic [11:0] c_addr_cycleh     = 12'hC80;
    localparam logic [11:0] c_addr_instreth   = 12'hC82;
    localparam logic [11:0] c_addr_mvendorid  = 12'hF11;
    localparam logic [11:0] c_addr_marchid    = 12'hF12;
    localparam logic [11:0] c_addr_mimpid     = 12'hF13;
    localparam logic [11:0] c_addr_mhartid    = 12'hF14;

    // csr_op encoding
    localparam logic [1:0] c_op_read  = 2'd0;
    localparam logic [1:0] c_op_write = 2'd1;
    localparam logic [1:0] c_op_set   = 2'd2;
    localparam logic [1:0] c_op_clear = 2'd3;

    // Exception cause codes
    localparam logic [3:0] c_exc_iaddr_misalign = 4'd0;
    localparam logic [3:0] c_exc_illegal_instr  = 4'd2;
    localparam logic [3:0] c_exc_breakpoint     = 4'd3;
    localparam logic [3:0] c_exc_laddr_misalign = 4'd4;
    localparam logic [3:0] c_exc_saddr_misalign = 4'd6;
    localparam logic [3:0] c_exc_ecall_m        = 4'd11;

    // Interrupt cause codes (also the mie/mip bit positions)
    localparam logic [3:0] c_int_msi = 4'd3;
    localparam logic [3:0] c_int_mti = 4'd7;
    localparam logic [3:0] c_int_mei = 4'd11;

    // mstatus / mie / mip bit indices
    localparam int c_bit_mie  = 3;
    localparam int c_bit_mpie = 7;
    localparam int c_bit_msi  = 3;
    localparam int c_bit_mti  = 7;
    localparam int c_bit_mei  = 11;

    // True when a cause code is one this hart can actually raise
    function automatic logic cause_ok(input logic is_int, input logic [3:0] code);
        if (is_int) begin
            return (code == c_int_msi) || (code == c_int_mti) || (code == c_int_mei);
        end
        return (code == c_exc_iaddr_misalign) || (code == c_exc_illegal_instr) ||
               (code == c_exc_breakpoint)     || (code == c_exc_laddr_misalign) ||
               (code == c_exc_saddr_misalign) || (code == c_exc_ecall_m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_counter64.sv
`default_nettype none
// ============================================================================
//  Module      : csr_counter64
//  Description : 64-bit free/enable counter with independent low/high
//                32-bit write ports; any write wins over the increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_counter64 (
    input  logic        clk,
    input  logic        rstl,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] din_lo,
    input  logic [31:0] din_hi,
    output logic [63:0] count
);

    logic [63:0] r_count;

    // Write replaces the addressed half(s) and suppresses counting that cycle
    always_ff @(posedge clk) begin
        if (!rstl) begin
            r_count <= 64'd0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) r_count[31:0]  <= din_lo;
            if (wr_hi) r_count[63:32] <= din_hi;
        end else if (inc) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
//  Module      : csr_file
//  Description : Machine-mode CSR file: CSR access decode, trap entry/exit,
//                level interrupts and 64-bit mcycle/minstret counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_file
    import csr_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter int unsigned     HART_ID     = 0
) (
    input  logic            clk,
    input  logic            rstl,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_din,
    output logic [XLEN-1:0] csr_dout,
    output logic            csr_illegal,
    input  logic            exc_valid,
    input  logic [3:0]      exc_code,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            is_mret,
    input  logic            instr_retire,
    input  logic [XLEN-1:0] pc_now,
    input  logic            irq_msi,
    input  logic            irq_mti,
    input  logic            irq_mei,
    output logic            trap_pc,
    output logic [XLEN-1:0] pc_trap
);

    // MXL in the top two bits, extension I at bit 8
    localparam logic [XLEN-1:0] c_misa = {((XLEN == 32) ? 2'b01 : 2'b10),
                                          {(XLEN-28){1'b0}}, 26'h100};

    logic            r_mie, r_mpie;
    logic            r_msie, r_mtie, r_meie;
    logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;

    logic [63:0]     w_cycle, w_instret;
    logic [XLEN-1:0] w_cyc_rd, w_cyc_rdh, w_ins_rd, w_ins_rdh;
    logic [XLEN-1:0] w_mstatus, w_mie_rd, w_mip_rd, w_wdata, w_trap_cause;
    logic [31:0]     w_din_hi;
    logic            w_impl, w_illegal, w_wr_en;
    logic            w_int_take, w_trap;
    logic [3:0]      w_int_code;

    // Counter read views and high-half write data depend on XLEN
    generate
        if (XLEN == 64) begin : g_x64
            assign w_cyc_rd  = w_cycle[XLEN-1:0];
            assign w_ins_rd  = w_instret[XLEN-1:0];
            assign w_cyc_rdh = '0;
            assign w_ins_rdh = '0;
            assign w_din_hi  = w_wdata[XLEN-1:XLEN-32];
        end else begin : g_x32
            assign w_cyc_rd  = w_cycle[XLEN-1:0];
            assign w_ins_rd  = w_instret[XLEN-1:0];
            assign w_cyc_rdh = w_cycle[63:XLEN];
            assign w_ins_rdh = w_instret[63:XLEN];
            assign w_din_hi  = w_wdata[31:0];
        end
    endgenerate

    // Assemble composite register views
    always_comb begin
        w_mstatus             = '0;
        w_mstatus[12:11]      = 2'b11;
        w_mstatus[c_bit_mpie] = r_mpie;
        w_mstatus[c_bit_mie]  = r_mie;
        w_mie_rd              = '0;
        w_mie_rd[c_bit_msi]   = r_msie;
        w_mie_rd[c_bit_mti]   = r_mtie;
        w_mie_rd[c_bit_mei]   = r_meie;
        w_mip_rd              = '0;
        w_mip_rd[c_bit_msi]   = irq_msi;
        w_mip_rd[c_bit_mti]   = irq_mti;
        w_mip_rd[c_bit_mei]   = irq_mei;
    end

    // Read mux and implemented-address decode
    always_comb begin
        csr_dout = '0;
        w_impl   = 1'b1;
        case (csr_addr)
            c_addr_mstatus:                    csr_dout = w_mstatus;
            c_addr_misa:                       csr_dout = c_misa;
            c_addr_mie:                        csr_dout = w_mie_rd;
            c_addr_mtvec:                      csr_dout = r_mtvec;
            c_addr_mscratch:                   csr_dout = r_mscratch;
            c_addr_mepc:                       csr_dout = r_mepc;
            c_addr_mcause:                     csr_dout = r_mcause;
            c_addr_mtval:                      csr_dout = r_mtval;
            c_addr_mip:                        csr_dout = w_mip_rd;
            c_addr_mcycle, c_addr_cycle:       csr_dout = w_cyc_rd;
            c_addr_minstret, c_addr_instret:   csr_dout = w_ins_rd;
            c_addr_mcycleh, c_addr_cycleh: begin
                csr_dout = w_cyc_rdh;
                w_impl   = (XLEN == 32);
            end
            c_addr_minstreth, c_addr_instreth: begin
                csr_dout = w_ins_rdh;
                w_impl   = (XLEN == 32);
            end
            c_addr_mvendorid, c_addr_marchid, c_addr_mimpid: csr_dout = '0;
            c_addr_mhartid:                    csr_dout = XLEN'(HART_ID);
            default:                           w_impl   = 1'b0;
        endcase
    end

    // Access legality, write data and interrupt arbitration
    always_comb begin
        w_illegal = !w_impl || ((csr_addr[11:10] == 2'b11) && (csr_op != c_op_read));
        case (csr_op)
            c_op_write: w_wdata = csr_din;
            c_op_set:   w_wdata = csr_dout | csr_din;
            c_op_clear: w_wdata = csr_dout & ~csr_din;
            default:    w_wdata = csr_dout;
        endcase

        w_int_take = r_mie && !exc_valid &&
                     ((r_meie && irq_mei) || (r_msie && irq_msi) || (r_mtie && irq_mti));
        if (r_meie && irq_mei)      w_int_code = c_int_mei;
        else if (r_msie && irq_msi) w_int_code = c_int_msi;
        else                        w_int_code = c_int_mti;

        w_trap                = exc_valid || w_int_take;
        w_trap_cause          = '0;
        w_trap_cause[XLEN-1]  = !exc_valid;
        w_trap_cause[3:0]     = exc_valid ? exc_code : w_int_code;

        w_wr_en = rstl && (csr_op != c_op_read) && !w_illegal && !w_trap && !is_mret;
    end

    // Fetch redirect; vectored mode offsets interrupts only
    always_comb begin
        csr_illegal = rstl && w_illegal;
        trap_pc     = rstl && (w_trap || is_mret);
        pc_trap     = '0;
        if (rstl && w_trap) begin
            pc_trap = {r_mtvec[XLEN-1:2], 2'b00};
            if (!exc_valid && r_mtvec[0]) pc_trap = pc_trap + XLEN'({w_int_code, 2'b00});
        end else if (rstl && is_mret) begin
            pc_trap = r_mepc;
        end
    end

    // Architectural state: trap > mret > CSR write
    always_ff @(posedge clk) begin
        if (!rstl) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_msie     <= 1'b0;
            r_mtie     <= 1'b0;
            r_meie     <= 1'b0;
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
        end else if (w_trap) begin
            r_mepc   <= {pc_now[XLEN-1:1], 1'b0};
            r_mcause <= w_trap_cause;
            r_mtval  <= exc_valid ? exc_tval : '0;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (is_mret) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_wr_en) begin
            case (csr_addr)
                c_addr_mstatus: begin
                    r_mie  <= w_wdata[c_bit_mie];
                    r_mpie <= w_wdata[c_bit_mpie];
                end
                c_addr_mie: begin
                    r_msie <= w_wdata[c_bit_msi];
                    r_mtie <= w_wdata[c_bit_mti];
                    r_meie <= w_wdata[c_bit_mei];
                end
                c_addr_mtvec:    r_mtvec    <= {w_wdata[XLEN-1:2], 1'b0, (w_wdata[1:0] == 2'b01)};
                c_addr_mscratch: r_mscratch <= w_wdata;
                c_addr_mepc:     r_mepc     <= {w_wdata[XLEN-1:1], 1'b0};
                c_addr_mcause: begin
                    if ((w_wdata[XLEN-2:4] == '0) && cause_ok(w_wdata[XLEN-1], w_wdata[3:0]))
                        r_mcause <= w_wdata;
                end
                c_addr_mtval:    r_mtval    <= w_wdata;
                default: ;
            endcase
        end
    end

    csr_counter64 u_mcycle (
        .clk    (clk),
        .rstl   (rstl),
        .inc    (1'b1),
        .wr_lo  (w_wr_en && (csr_addr == c_addr_mcycle)),
        .wr_hi  (w_wr_en && ((csr_addr == c_addr_mcycleh) ||
                             ((XLEN == 64) && (csr_addr == c_addr_mcycle)))),
        .din_lo (w_wdata[31:0]),
        .din_hi (w_din_hi),
        .count  (w_cycle)
    );

    csr_counter64 u_minstret (
        .clk    (clk),
        .rstl   (rstl),
        .inc    (instr_retire),
        .wr_lo  (w_wr_en && (csr_addr == c_addr_minstret)),
        .wr_hi  (w_wr_en && ((csr_addr == c_addr_minstreth) ||
                             ((XLEN == 64) && (csr_addr == c_addr_minstret)))),
        .din_lo (w_wdata[31:0]),
        .din_hi (w_din_hi),
        .count  (w_instret)
    );

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csr_file
//  Description : Directed self-checking bench for csr_file (XLEN=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rstl;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_din;
    logic [31:0] csr_dout;
    logic        csr_illegal;
    logic        exc_valid;
    logic [3:0]  exc_code;
    logic [31:0] exc_tval;
    logic        is_mret;
    logic        instr_retire;
    logic [31:0] pc_now;
    logic        irq_msi, irq_mti, irq_mei;
    logic        trap_pc;
    logic [31:0] pc_trap;

    int n_cmp = 0;
    int n_err = 0;

    csr_file #(.XLEN(32), .MTVEC_RESET(32'h0), .HART_ID(3)) dut (
        .clk          (clk),
        .rstl         (rstl),
        .csr_addr     (csr_addr),
        .csr_op       (csr_op),
        .csr_din      (csr_din),
        .csr_dout     (csr_dout),
        .csr_illegal  (csr_illegal),
        .exc_valid    (exc_valid),
        .exc_code     (exc_code),
        .exc_tval     (exc_tval),
        .is_mret      (is_mret),
        .instr_retire (instr_retire),
        .pc_now       (pc_now),
        .irq_msi      (irq_msi),
        .irq_mti      (irq_mti),
        .irq_mei      (irq_mei),
        .trap_pc      (trap_pc),
        .pc_trap      (pc_trap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csr_addr = a;
        csr_op   = op;
        csr_din  = d;
        #1;
    endtask

    task automatic test_reset();
        rstl = 1'b0; exc_valid = 1'b1; exc_code = 4'd2;
        drive(12'h345, 2'd1, 32'h1);
        tick(); tick();
        n_cmp++; if (trap_pc !== 1'b0) begin n_err++; $display("FAIL rst_trap_pc: got %b want 0", trap_pc); end
        n_cmp++; if (pc_trap !== 32'h0) begin n_err++; $display("FAIL rst_pc_trap: got %h want 0", pc_trap); end
        n_cmp++; if (csr_illegal !== 1'b0) begin n_err++; $display("FAIL rst_illegal: got %b want 0", csr_illegal); end
        exc_valid = 1'b0;
        drive(12'h000, 2'd0, 32'h0);
        rstl = 1'b1;
        drive(12'h301, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h40000100) begin n_err++; $display("FAIL misa: got %h want 40000100", csr_dout); end
        drive(12'h300, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h00001800) begin n_err++; $display("FAIL mstatus_rst: got %h want 00001800", csr_dout); end
        drive(12'hF14, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h3) begin n_err++; $display("FAIL hartid: got %h want 3", csr_dout); end
        n_cmp++; if (csr_illegal !== 1'b0) begin n_err++; $display("FAIL hartid_read_illegal: got %b want 0", csr_illegal); end
        drive(12'h305, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h0) begin n_err++; $display("FAIL mtvec_rst: got %h want 0", csr_dout); end
    endtask

    task automatic test_interrupt();
        drive(12'h305, 2'd1, 32'h80000001); tick();
        drive(12'h300, 2'd2, 32'h8);        tick();
        drive(12'h304, 2'd2, 32'h800);      tick();
        pc_now = 32'h200; irq_mei = 1'b1;
        drive(12'h342, 2'd0, 32'h0);
        n_cmp++; if (trap_pc !== 1'b1) begin n_err++; $display("FAIL irq_trap_pc: got %b want 1", trap_pc); end
        n_cmp++; if (pc_trap !== 32'h8000002C) begin n_err++; $display("FAIL irq_pc_trap: got %h want 8000002c", pc_trap); end
        tick();
        irq_mei = 1'b0;
        drive(12'h342, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h8000000B) begin n_err++; $display("FAIL irq_mcause: got %h want 8000000b", csr_dout); end
        drive(12'h300, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h00001880) begin n_err++; $display("FAIL irq_mstatus: got %h want 00001880", csr_dout); end
        drive(12'h341, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h200) begin n_err++; $display("FAIL irq_mepc: got %h want 200", csr_dout); end
        drive(12'h343, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h0) begin n_err++; $display("FAIL irq_mtval: got %h want 0", csr_dout); end
    endtask

    task automatic test_exception();
        drive(12'h300, 2'd2, 32'h8);  tick();
        drive(12'h304, 2'd2, 32'h80); tick();
        irq_mti = 1'b1; exc_valid = 1'b1; exc_code = 4'd2; exc_tval = 32'hDEAD; pc_now = 32'h100;
        drive(12'h340, 2'd1, 32'h55);
        n_cmp++; if (trap_pc !== 1'b1) begin n_err++; $display("FAIL exc_trap_pc: got %b want 1", trap_pc); end
        n_cmp++; if (pc_trap !== 32'h80000000) begin n_err++; $display("FAIL exc_pc_trap: got %h want 80000000", pc_trap); end
        tick();
        exc_valid = 1'b0; irq_mti = 1'b0;
        drive(12'h342, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h2) begin n_err++; $display("FAIL exc_mcause: got %h want 2", csr_dout); end
        drive(12'h343, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'hDEAD) begin n_err++; $display("FAIL exc_mtval: got %h want dead", csr_dout); end
        drive(12'h341, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h100) begin n_err++; $display("FAIL exc_mepc: got %h want 100", csr_dout); end
        drive(12'h340, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h0) begin n_err++; $display("FAIL exc_lost_write: got %h want 0", csr_dout); end
    endtask

    task automatic test_mret();
        drive(12'h300, 2'd1, 32'h80); tick();
        is_mret = 1'b1;
        drive(12'h000, 2'd0, 32'h0);
        n_cmp++; if (trap_pc !== 1'b1) begin n_err++; $display("FAIL mret_trap_pc: got %b want 1", trap_pc); end
        n_cmp++; if (pc_trap !== 32'h100) begin n_err++; $display("FAIL mret_pc_trap: got %h want 100", pc_trap); end
        tick();
        is_mret = 1'b0;
        drive(12'h300, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h00001888) begin n_err++; $display("FAIL mret_mstatus: got %h want 00001888", csr_dout); end
        n_cmp++; if (trap_pc !== 1'b0) begin n_err++; $display("FAIL idle_trap_pc: got %b want 0", trap_pc); end
    endtask

    task automatic test_counters();
        drive(12'hB00, 2'd1, 32'hFFFFFFFF); tick();
        drive(12'hB80, 2'd1, 32'h0);        tick();
        drive(12'hB80, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h0) begin n_err++; $display("FAIL mcycleh_before: got %h want 0", csr_dout); end
        drive(12'hB00, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mcycle_held: got %h want ffffffff", csr_dout); end
        tick();
        drive(12'hB80, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h1) begin n_err++; $display("FAIL mcycleh_carry: got %h want 1", csr_dout); end
        drive(12'hB00, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h0) begin n_err++; $display("FAIL mcycle_wrap: got %h want 0", csr_dout); end
        tick();
        drive(12'hC00, 2'd1, 32'h1234);
        n_cmp++; if (csr_illegal !== 1'b1) begin n_err++; $display("FAIL ro_write_illegal: got %b want 1", csr_illegal); end
        n_cmp++; if (csr_dout !== 32'h1) begin n_err++; $display("FAIL cycle_shadow: got %h want 1", csr_dout); end
        tick();
        drive(12'hC00, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h2) begin n_err++; $display("FAIL ro_write_ignored: got %h want 2", csr_dout); end
        drive(12'hC80, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h1) begin n_err++; $display("FAIL cycleh_shadow: got %h want 1", csr_dout); end
        drive(12'hB02, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h0) begin n_err++; $display("FAIL minstret_idle: got %h want 0", csr_dout); end
        instr_retire = 1'b1;
        tick(); tick(); tick();
        instr_retire = 1'b0;
        drive(12'hC02, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h3) begin n_err++; $display("FAIL minstret_count: got %h want 3", csr_dout); end
    endtask

    task automatic test_warl_illegal();
        drive(12'h342, 2'd1, 32'h80000005);
        n_cmp++; if (csr_illegal !== 1'b0) begin n_err++; $display("FAIL mcause_wr_illegal: got %b want 0", csr_illegal); end
        tick();
        drive(12'h342, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h2) begin n_err++; $display("FAIL mcause_bad_dropped: got %h want 2", csr_dout); end
        drive(12'h345, 2'd1, 32'hABC);
        n_cmp++; if (csr_illegal !== 1'b1) begin n_err++; $display("FAIL unimpl_illegal: got %b want 1", csr_illegal); end
        drive(12'h305, 2'd1, 32'h80000402); tick();
        drive(12'h305, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h80000400) begin n_err++; $display("FAIL mtvec_mode2: got %h want 80000400", csr_dout); end
        drive(12'h341, 2'd1, 32'h203); tick();
        drive(12'h341, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h202) begin n_err++; $display("FAIL mepc_align: got %h want 202", csr_dout); end
        drive(12'h342, 2'd3, 32'h2); tick();
        drive(12'h342, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h0) begin n_err++; $display("FAIL mcause_clear: got %h want 0", csr_dout); end
        irq_msi = 1'b1;
        drive(12'h344, 2'd1, 32'hFFFFFFFF);
        n_cmp++; if (csr_illegal !== 1'b0) begin n_err++; $display("FAIL mip_wr_illegal: got %b want 0", csr_illegal); end
        tick();
        drive(12'h344, 2'd0, 32'h0);
        n_cmp++; if (csr_dout !== 32'h8) begin n_err++; $display("FAIL mip_mirror: got %h want 8", csr_dout); end
        irq_msi = 1'b0;
    endtask

    initial begin
        rstl = 1'b0; csr_addr = '0; csr_op = '0; csr_din = '0;
        exc_valid = 1'b0; exc_code = '0; exc_tval = '0; is_mret = 1'b0;
        instr_retire = 1'b0; pc_now = '0; irq_msi = 1'b0; irq_mti = 1'b0; irq_mei = 1'b0;
        test_reset();
        test_interrupt();
        test_exception();
        test_mret();
        test_counters();
        test_warl_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
